lfsr_tap_scanner: RTL



---
 rtl/lfsr_tap_scanner.sv | 129 ++++++++++++
 1 files changed

// File: rtl/lfsr_tap_scanner.sv
// Scans every non-zero feedback-tap polynomial of a WIDTH-bit Fibonacci LFSR from a common seed
// and reports period/maximality per polynomial. Optional macro: LFSR_SCAN_MAXONLY_EN.
module lfsr_tap_scanner #(
  parameter int WIDTH     = 3,
  parameter int MAX_STEPS = 2**WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] seed,
  output logic             busy,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_taps,
  output logic [WIDTH:0]   res_period,
  output logic             res_maximal,
  output logic             done
);

  localparam logic [WIDTH:0] MAX_C   = (WIDTH+1)'(MAX_STEPS);
  localparam logic [WIDTH:0] MAX_PER = (WIDTH+1)'((2**WIDTH) - 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_STEP, S_REPORT, S_DONE} state_t;

  state_t           st;
  logic [WIDTH-1:0] seed_q;
  logic [WIDTH-1:0] taps;
  logic [WIDTH-1:0] lfsr;
  logic [WIDTH:0]   cnt;

  logic [WIDTH-1:0] lfsr_nxt;
  logic [WIDTH:0]   cnt_inc;
  logic             hit;
  logic             stop;
  logic [WIDTH:0]   per_nxt;
  logic             max_nxt;
  logic             last_taps;

  always_comb begin
    lfsr_nxt  = {lfsr[WIDTH-2:0], ^(lfsr & taps)};
    cnt_inc   = cnt + (WIDTH+1)'(1);
    hit       = (lfsr_nxt == seed_q);
    stop      = hit || (cnt_inc == MAX_C);
    per_nxt   = hit ? cnt_inc : '0;
    max_nxt   = (per_nxt == MAX_PER);
    last_taps = (taps == {WIDTH{1'b1}});
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      st          <= S_IDLE;
      seed_q      <= '0;
      taps        <= '0;
      lfsr        <= '0;
      cnt         <= '0;
      busy        <= 1'b0;
      res_valid   <= 1'b0;
      res_taps    <= '0;
      res_period  <= '0;
      res_maximal <= 1'b0;
      done        <= 1'b0;
    end else begin
      case (st)
        S_IDLE: begin
          if (start) begin
            seed_q <= seed;
            taps   <= WIDTH'(1);
            busy   <= 1'b1;
            st     <= S_LOAD;
          end
        end
        S_LOAD: begin
          lfsr <= seed_q;
          cnt  <= '0;
          st   <= S_STEP;
        end
        S_STEP: begin
          lfsr <= lfsr_nxt;
          cnt  <= cnt_inc;
          if (stop) begin
`ifdef LFSR_SCAN_MAXONLY_EN
            if (!max_nxt) begin
              // Non-maximal result is dropped: move straight on to the next tap set.
              if (last_taps) begin
                done <= 1'b1;
                st   <= S_DONE;
              end else begin
                taps <= taps + WIDTH'(1);
                st   <= S_LOAD;
              end
            end else begin
              res_valid   <= 1'b1;
              res_taps    <= taps;
              res_period  <= per_nxt;
              res_maximal <= max_nxt;
              st          <= S_REPORT;
            end
`else
            res_valid   <= 1'b1;
            res_taps    <= taps;
            res_period  <= per_nxt;
            res_maximal <= max_nxt;
            st          <= S_REPORT;
`endif
          end
        end
        S_REPORT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            if (last_taps) begin
              done <= 1'b1;
              st   <= S_DONE;
            end else begin
              taps <= taps + WIDTH'(1);
              st   <= S_LOAD;
            end
          end
        end
        S_DONE: begin
          done <= 1'b0;
          busy <= 1'b0;
          st   <= S_IDLE;
        end
        default: st <= S_IDLE;
      endcase
    end
  end

endmodule
